lz77_match_sched: RTL and testbench
===================================

Name: lz77_match_sched

Overview:
Sequences one LZ77 compression block.
- Loads DEPTH input bytes into the window RAM.
- For each cursor position, searches all earlier RAM positions for the longest match.
- Emits one literal or (offset, length) match token per step over a valid/ready handshake.
- Sits between the byte input stream and the token encoder, and is the sole owner of the window RAM's write port and two sync read ports.

Parameters:
DEPTH, 64, block/window size in bytes
AW, 6, RAM address width (log2 DEPTH)
LW, 4, token length field width
MAX_LEN, 15, longest match reported (≤ 2^LW−1)
MIN_MATCH, 3, shortest length emitted as a match

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  reset, asynchronous, active-high
start  in  1  begin a block; sampled in IDLE only
in_valid  in  1  input byte valid
in_data  in  8  input byte
in_ready  out  1  byte accepted when in_valid&&in_ready
ram_we  out  1  RAM write enable
ram_waddr  out  AW  write address
ram_wdata  out  8  write data
ram_raddr_a  out  AW  read port A address (candidate)
ram_raddr_b  out  AW  read port B address (cursor)
ram_rdata_a  in  8  port A data, valid 1 cycle after address
ram_rdata_b  in  8  port B data, valid 1 cycle after address
tok_valid  out  1  token valid
tok_ready  in  1  token consumer ready
tok_is_match  out  1  1=match token, 0=literal
tok_offset  out  AW  match distance c−s (1..DEPTH−1); 0 for literal
tok_length  out  LW  match length; 0 for literal
tok_literal  out  8  byte at cursor; always valid with tok_valid
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse when a block completes

Behaviour:
- Reset: Rst asynchronous, active-high. Every output, the state register, and all counters go to 0 (state = IDLE). The current block is abandoned.
- State register: one-hot, states IDLE, LOAD, LIT_RD, LIT_CAP, SCAN_RD, SCAN_CMP, EMIT, DONE.
- IDLE:
  - in_ready=0.
  - start=1 → LOAD, wcnt=0.
- LOAD:
  - in_ready=1.
  - Each accepted byte: ram_we=1, waddr=wcnt, wdata=in_data (combinational from the handshake), wcnt++.
  - After the DEPTH-th accept → LIT_RD with cursor c=0.
  - start is ignored while busy.
- LIT_RD:
  - raddr_b=c → LIT_CAP.
- LIT_CAP:
  - Latch literal = rdata_b; clear best_len=0, best_off=0.
  - If c==0 → EMIT.
  - Otherwise s=c−1, k=0 → SCAN_RD.
- SCAN_RD:
  - raddr_a=s+k, raddr_b=c+k → SCAN_CMP.
- SCAN_CMP, with eq = (rdata_a==rdata_b):
  - If eq and k+1<MAX_LEN and c+k+1<DEPTH: k++ → SCAN_RD.
  - Otherwise candidate length len = k+eq.
  - If len > best_len (strict): best_len=len, best_off=c−s. Strict compare gives the nearest offset on ties.
  - Then if s==0 or best_len==MAX_LEN → EMIT; else s−−, k=0 → SCAN_RD.
- Overlapping matches (s+k ≥ c) are legal.
- Read address widths: all read addresses stay < DEPTH; the cursor counter is AW+1 bits.
- EMIT:
  - tok_valid=1. If best_len ≥ MIN_MATCH: is_match=1, offset=best_off, length=best_len. Otherwise is_match=0, offset=0, length=0.
  - tok_literal = latched literal in both cases.
  - Fields stay stable while tok_valid && !tok_ready.
  - On handshake: c += (is_match ? length : 1).
  - If new c ≥ DEPTH → DONE; else → LIT_RD.
- DONE:
  - done=1 for one cycle → IDLE. busy falls in IDLE.
- Per-step latency: 2 cycles literal fetch, plus 2 cycles per compared byte, plus ≥1 cycle EMIT.
- Block output: the emitted tokens cover exactly DEPTH bytes; the cursor never overshoots.

Decomposition:
- Shared package lz77_pkg: DEPTH, AW, LW, MAX_LEN, MIN_MATCH defaults, the one-hot state encodings, and the token field layout used by the downstream encoder.
- One sub-module: lz77_best_tracker. It holds best_len/best_off, applies the strict-greater update, and takes a clear on LIT_CAP.

Test Plan:
1. Load bytes 0x00..0x3F, tok_ready=1 → 64 literal tokens, literal=i, offset=0, length=0; one done pulse; busy low after.
2. Load byte[i]=0x41+(i%3) → literals A,B,C; matches (off3,len15) at c=3,18,33,48; literal 'A' at c=63; 8 tokens total, then done.
3. Load 64×0x00 → literal at c=0; match (off1,len15) at c=1,16,31,46; (off1,len3) at c=61; 6 tokens. Checks nearest-offset tie-break and MAX_LEN early exit.
4. Case 2 with tok_ready held low 5 cycles at the first match → tok_valid stays high, fields stay (1,3,15,'A'), cursor does not advance.
5. Assert Rst during SCAN_CMP of case 2 → all outputs 0 immediately, asynchronously; a new start reloads and reproduces case 2's token stream.
6. Pulse start during LOAD, and gap in_valid for 3 cycles → start ignored, in_ready stays 1, exactly 64 RAM writes at addresses 0..63.

Source files
------------

// File: rtl/lz77_pkg.sv
// Shared constants, FSM encoding and token layout for the LZ77 match scheduler
// and the downstream token encoder.
package lz77_pkg;
    localparam int DEPTH     = 64;
    localparam int AW        = 6;
    localparam int LW        = 4;
    localparam int MAX_LEN   = 15;
    localparam int MIN_MATCH = 3;

    localparam logic [AW:0]   DEPTH_W     = (AW+1)'(DEPTH);
    localparam logic [LW-1:0] MAX_LEN_W   = LW'(MAX_LEN);
    localparam logic [LW-1:0] MIN_MATCH_W = LW'(MIN_MATCH);

    // One-hot with an all-zero IDLE so that reset clears the whole register.
    typedef enum logic [6:0] {
        S_IDLE     = 7'b0000000,
        S_LOAD     = 7'b0000001,
        S_LIT_RD   = 7'b0000010,
        S_LIT_CAP  = 7'b0000100,
        S_SCAN_RD  = 7'b0001000,
        S_SCAN_CMP = 7'b0010000,
        S_EMIT     = 7'b0100000,
        S_DONE     = 7'b1000000
    } state_e;

    typedef struct packed {
        logic          is_match;
        logic [AW-1:0] offset;
        logic [LW-1:0] length;
        logic [7:0]    literal;
    } token_t;
endpackage

// File: rtl/lz77_match_sched_if.sv
// Byte-input, window-RAM and token-output signals of the match scheduler.
interface lz77_match_sched_if;
    import lz77_pkg::*;

    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [7:0]    ram_wdata;
    logic [AW-1:0] ram_raddr_a;
    logic [AW-1:0] ram_raddr_b;
    logic [7:0]    ram_rdata_a;
    logic [7:0]    ram_rdata_b;
    logic          tok_valid;
    logic          tok_ready;
    logic          tok_is_match;
    logic [AW-1:0] tok_offset;
    logic [LW-1:0] tok_length;
    logic [7:0]    tok_literal;

    modport master (
        input  in_valid, in_data, ram_rdata_a, ram_rdata_b, tok_ready,
        output in_ready, ram_we, ram_waddr, ram_wdata, ram_raddr_a, ram_raddr_b,
               tok_valid, tok_is_match, tok_offset, tok_length, tok_literal
    );

    modport slave (
        output in_valid, in_data, ram_rdata_a, ram_rdata_b, tok_ready,
        input  in_ready, ram_we, ram_waddr, ram_wdata, ram_raddr_a, ram_raddr_b,
               tok_valid, tok_is_match, tok_offset, tok_length, tok_literal
    );
endinterface

// File: rtl/lz77_best_tracker.sv
// Holds the longest match found so far for the current cursor; only a strictly
// longer candidate replaces it, so the nearest offset wins ties.
module lz77_best_tracker
    import lz77_pkg::*;
(
    input  logic          Clk,
    input  logic          Rst,
    input  logic          clr_i,
    input  logic          upd_i,
    input  logic [LW-1:0] cand_len_i,
    input  logic [AW-1:0] cand_off_i,
    output logic [LW-1:0] best_len_o,
    output logic [AW-1:0] best_off_o,
    output logic [LW-1:0] best_len_nxt_o
);
    logic [LW-1:0] best_len_q, best_len_d;
    logic [AW-1:0] best_off_q, best_off_d;

    always_comb begin
        best_len_d = best_len_q;
        best_off_d = best_off_q;
        if (clr_i) begin
            best_len_d = '0;
            best_off_d = '0;
        end else if (upd_i && (cand_len_i > best_len_q)) begin
            best_len_d = cand_len_i;
            best_off_d = cand_off_i;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            best_len_q <= '0;
            best_off_q <= '0;
        end else begin
            best_len_q <= best_len_d;
            best_off_q <= best_off_d;
        end
    end

    assign best_len_o     = best_len_q;
    assign best_off_o     = best_off_q;
    assign best_len_nxt_o = best_len_d;
endmodule

// File: rtl/lz77_match_sched.sv
// LZ77 block sequencer: loads DEPTH bytes into the window RAM, then walks the
// cursor emitting one literal or (offset, length) token per step.
module lz77_match_sched
    import lz77_pkg::*;
(
    input  logic Clk,
    input  logic Rst,
    input  logic start,
    output logic busy,
    output logic done,
    lz77_match_sched_if.master bus
);
    state_e        state_q, state_d;
    logic [AW:0]   wcnt_q, wcnt_d;
    logic [AW:0]   c_q, c_d;
    logic [AW-1:0] s_q, s_d;
    logic [LW-1:0] k_q, k_d;
    logic [7:0]    lit_q, lit_d;

    logic [LW-1:0] best_len, best_len_nxt;
    logic [AW-1:0] best_off;
    logic [AW:0]   k_ext, ck, ck1, c_next;
    logic [LW-1:0] k_inc, cand_len, step;
    logic [AW-1:0] cand_off;
    logic          accept, eq, cont, upd, clr, emit_match;

    assign k_ext      = {{(AW+1-LW){1'b0}}, k_q};
    assign ck         = c_q + k_ext;
    assign ck1        = ck + 1'b1;
    assign k_inc      = k_q + 1'b1;
    assign eq         = (bus.ram_rdata_a == bus.ram_rdata_b);
    // Extend while bytes agree, the length cap is not reached and the cursor run stays inside the block.
    assign cont       = eq && (k_inc < MAX_LEN_W) && (ck1 < DEPTH_W);
    assign cand_len   = k_q + {{(LW-1){1'b0}}, eq};
    assign cand_off   = c_q[AW-1:0] - s_q;
    assign upd        = (state_q == S_SCAN_CMP) && !cont;
    assign clr        = (state_q == S_LIT_CAP);
    assign emit_match = (best_len >= MIN_MATCH_W);
    assign step       = emit_match ? best_len : {{(LW-1){1'b0}}, 1'b1};
    assign c_next     = c_q + {{(AW+1-LW){1'b0}}, step};
    assign accept     = (state_q == S_LOAD) && bus.in_valid;

    lz77_best_tracker u_best (
        .Clk           (Clk),
        .Rst           (Rst),
        .clr_i         (clr),
        .upd_i         (upd),
        .cand_len_i    (cand_len),
        .cand_off_i    (cand_off),
        .best_len_o    (best_len),
        .best_off_o    (best_off),
        .best_len_nxt_o(best_len_nxt)
    );

    always_comb begin
        state_d          = state_q;
        wcnt_d           = wcnt_q;
        c_d              = c_q;
        s_d              = s_q;
        k_d              = k_q;
        lit_d            = lit_q;
        busy             = (state_q != S_IDLE);
        done             = 1'b0;
        bus.in_ready     = 1'b0;
        bus.ram_we       = 1'b0;
        bus.ram_waddr    = '0;
        bus.ram_wdata    = '0;
        bus.ram_raddr_a  = '0;
        bus.ram_raddr_b  = '0;
        bus.tok_valid    = 1'b0;
        bus.tok_is_match = 1'b0;
        bus.tok_offset   = '0;
        bus.tok_length   = '0;
        bus.tok_literal  = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    wcnt_d  = '0;
                end
            end
            S_LOAD: begin
                bus.in_ready = 1'b1;
                if (accept) begin
                    bus.ram_we    = 1'b1;
                    bus.ram_waddr = wcnt_q[AW-1:0];
                    bus.ram_wdata = bus.in_data;
                    wcnt_d        = wcnt_q + 1'b1;
                    if (wcnt_q == DEPTH_W - 1'b1) begin
                        state_d = S_LIT_RD;
                        c_d     = '0;
                    end
                end
            end
            S_LIT_RD: begin
                bus.ram_raddr_b = c_q[AW-1:0];
                state_d         = S_LIT_CAP;
            end
            S_LIT_CAP: begin
                lit_d = bus.ram_rdata_b;
                if (c_q == '0) begin
                    state_d = S_EMIT;
                end else begin
                    s_d     = c_q[AW-1:0] - 1'b1;
                    k_d     = '0;
                    state_d = S_SCAN_RD;
                end
            end
            S_SCAN_RD: begin
                bus.ram_raddr_a = s_q + {{(AW-LW){1'b0}}, k_q};
                bus.ram_raddr_b = ck[AW-1:0];
                state_d         = S_SCAN_CMP;
            end
            S_SCAN_CMP: begin
                if (cont) begin
                    k_d     = k_inc;
                    state_d = S_SCAN_RD;
                end else if ((s_q == '0) || (best_len_nxt == MAX_LEN_W)) begin
                    state_d = S_EMIT;
                end else begin
                    s_d     = s_q - 1'b1;
                    k_d     = '0;
                    state_d = S_SCAN_RD;
                end
            end
            S_EMIT: begin
                bus.tok_valid    = 1'b1;
                bus.tok_is_match = emit_match;
                bus.tok_offset   = emit_match ? best_off : '0;
                bus.tok_length   = emit_match ? best_len : '0;
                bus.tok_literal  = lit_q;
                if (bus.tok_ready) begin
                    c_d     = c_next;
                    state_d = (c_next >= DEPTH_W) ? S_DONE : S_LIT_RD;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            c_q     <= '0;
            s_q     <= '0;
            k_q     <= '0;
            lit_q   <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            c_q     <= c_d;
            s_q     <= s_d;
            k_q     <= k_d;
            lit_q   <= lit_d;
        end
    end
endmodule

// File: tb/tb_lz77_match_sched.sv
// Directed bench for lz77_match_sched: window RAM model, token tables per block
// pattern, stall, mid-scan reset and load-quirk sequences.
module tb_lz77_match_sched;
    import lz77_pkg::*;

    typedef struct packed {
        logic       m;
        logic [5:0] off;
        logic [3:0] len;
        logic [7:0] lit;
    } exp_t;

    logic Clk = 1'b0;
    logic Rst;
    logic start;
    logic busy;
    logic done;
    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    logic [7:0] mem [DEPTH];

    lz77_match_sched_if bus ();

    lz77_match_sched dut (
        .Clk  (Clk),
        .Rst  (Rst),
        .start(start),
        .busy (busy),
        .done (done),
        .bus  (bus.master)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_wdata;
        bus.ram_rdata_a <= mem[bus.ram_raddr_a];
        bus.ram_rdata_b <= mem[bus.ram_raddr_b];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [7:0] pat(input int mode, input int i);
        case (mode)
            0:       return 8'(i);
            1:       return 8'(8'h41 + (i % 3));
            default: return 8'h00;
        endcase
    endfunction

    task automatic build(input int t);
        exp_q.delete();
        case (t)
            0: for (int i = 0; i < 64; i++) exp_q.push_back({1'b0, 6'd0, 4'd0, 8'(i)});
            1: begin
                exp_q.push_back({1'b0, 6'd0, 4'd0, 8'h41});
                exp_q.push_back({1'b0, 6'd0, 4'd0, 8'h42});
                exp_q.push_back({1'b0, 6'd0, 4'd0, 8'h43});
                for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 6'd3, 4'd15, 8'h41});
                exp_q.push_back({1'b0, 6'd0, 4'd0, 8'h41});
            end
            default: begin
                exp_q.push_back({1'b0, 6'd0, 4'd0, 8'h00});
                for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 6'd1, 4'd15, 8'h00});
                exp_q.push_back({1'b1, 6'd1, 4'd3, 8'h00});
            end
        endcase
    endtask

    task automatic load_block(input int mode, input bit quirks);
        int i   = 0;
        int cyc = 0;
        int gap = 0;
        @(posedge Clk); #1 start = 1'b1;
        @(posedge Clk); #1 start = 1'b0;
        while (i < 64 && cyc < 300) begin
            cyc++;
            if (quirks && i == 20 && gap < 3) begin
                bus.in_valid = 1'b0;
                gap++;
                @(negedge Clk);
                chk("gap_in_ready", 32'(bus.in_ready), 1);
                chk("gap_we", 32'(bus.ram_we), 0);
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = pat(mode, i);
                start        = quirks && (i == 10);
                @(negedge Clk);
                chk("load_we", 32'(bus.ram_we), 1);
                chk("load_waddr", 32'(bus.ram_waddr), i);
                chk("load_wdata", 32'(bus.ram_wdata), 32'(pat(mode, i)));
                if (bus.in_ready) i++;
            end
            @(posedge Clk); #1;
        end
        bus.in_valid = 1'b0;
        start        = 1'b0;
        chk("load_count", i, 64);
        @(negedge Clk);
        chk("post_load_in_ready", 32'(bus.in_ready), 0);
        chk("post_load_busy", 32'(busy), 1);
    endtask

    task automatic collect(input int stall_at);
        int idx   = 0;
        int cyc   = 0;
        int ndone = 0;
        bit stalled = 1'b0;
        bus.tok_ready = 1'b1;
        while (ndone == 0 && cyc < 20000) begin
            @(negedge Clk);
            cyc++;
            if (done) ndone++;
            if (bus.tok_valid) begin
                if (idx == stall_at && !stalled && idx < exp_q.size()) begin
                    bus.tok_ready = 1'b0;
                    stalled       = 1'b1;
                    repeat (5) begin
                        @(negedge Clk);
                        cyc++;
                        chk("stall_valid", 32'(bus.tok_valid), 1);
                        chk("stall_match", 32'(bus.tok_is_match), 32'(exp_q[idx].m));
                        chk("stall_off", 32'(bus.tok_offset), 32'(exp_q[idx].off));
                        chk("stall_len", 32'(bus.tok_length), 32'(exp_q[idx].len));
                        chk("stall_lit", 32'(bus.tok_literal), 32'(exp_q[idx].lit));
                    end
                    bus.tok_ready = 1'b1;
                end
                if (idx < exp_q.size()) begin
                    chk($sformatf("tok%0d_match", idx), 32'(bus.tok_is_match), 32'(exp_q[idx].m));
                    chk($sformatf("tok%0d_off", idx), 32'(bus.tok_offset), 32'(exp_q[idx].off));
                    chk($sformatf("tok%0d_len", idx), 32'(bus.tok_length), 32'(exp_q[idx].len));
                    chk($sformatf("tok%0d_lit", idx), 32'(bus.tok_literal), 32'(exp_q[idx].lit));
                end else begin
                    chk("extra_token", idx, exp_q.size());
                end
                idx++;
            end
        end
        chk("done_seen", ndone, 1);
        chk("token_count", idx, exp_q.size());
        @(negedge Clk);
        chk("done_one_cycle", 32'(done), 0);
        chk("busy_after_done", 32'(busy), 0);
    endtask

    initial begin
        int cyc;
        bit found;
        Rst           = 1'b1;
        start         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.tok_ready = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_tok_valid", 32'(bus.tok_valid), 0);
        chk("rst_ram_we", 32'(bus.ram_we), 0);
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        repeat (2) @(negedge Clk);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_in_ready", 32'(bus.in_ready), 0);

        // Distinct bytes: all literals.
        build(0);
        load_block(0, 1'b0);
        collect(-1);

        // Period-3 pattern: offset-3 matches capped at MAX_LEN.
        build(1);
        load_block(1, 1'b0);
        collect(-1);

        // All zeros: nearest offset wins ties, short tail match.
        build(2);
        load_block(2, 1'b0);
        collect(-1);

        // Consumer stall on the first match token.
        build(1);
        load_block(1, 1'b0);
        collect(3);

        // Reset while comparing c=2 against s=1, then a clean rerun.
        load_block(1, 1'b0);
        bus.tok_ready = 1'b1;
        cyc   = 0;
        found = 1'b0;
        while (!found && cyc < 2000) begin
            @(negedge Clk);
            cyc++;
            if (bus.ram_raddr_a == 6'd1 && bus.ram_raddr_b == 6'd2) found = 1'b1;
        end
        chk("scan_c2_found", 32'(found), 1);
        @(posedge Clk); #1;
        chk("pre_reset_busy", 32'(busy), 1);
        #1 Rst = 1'b1;
        #1;
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_tok_valid", 32'(bus.tok_valid), 0);
        chk("async_rst_raddr_a", 32'(bus.ram_raddr_a), 0);
        chk("async_rst_raddr_b", 32'(bus.ram_raddr_b), 0);
        chk("async_rst_in_ready", 32'(bus.in_ready), 0);
        @(negedge Clk);
        Rst = 1'b0;
        build(1);
        load_block(1, 1'b0);
        collect(-1);

        // Start pulse mid-load and a 3-cycle input gap.
        build(0);
        load_block(0, 1'b1);
        collect(-1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
